// File: rtl/prio_encoder_seq.sv
// rtl/prio_encoder_seq.sv - sequential priority encoder emitting set-bit indices highest first; PENC_ZERO_EMIT_EN enables all-zero beats
module prio_encoder_seq #(
    parameter int W  = 8,
    parameter int DW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  i,
    input  logic          i_valid,
    output logic          i_ready,
    output logic [DW-1:0] d,
    output logic          d_valid,
    input  logic          d_ready,
    output logic          d_last,
    output logic          none
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [W-1:0]  pending_q, pending_d;
    logic [DW-1:0] top_idx;
    logic [W-1:0]  top_onehot;
    logic          single_bit;
    logic          accept;
    logic          d_hs;
    logic          load_nonzero;

    // Ascending scan so the highest set bit is the one left standing.
    always_comb begin
        top_idx    = '0;
        top_onehot = '0;
        for (int k = 0; k < W; k++) begin
            if (pending_q[k]) begin
                top_idx    = DW'(k);
                top_onehot = '0;
                top_onehot[k] = 1'b1;
            end
        end
    end

    assign single_bit   = (pending_q != '0) && ((pending_q & (pending_q - W'(1))) == '0);
    assign accept       = i_valid && i_ready;
    assign d_hs         = d_valid && d_ready;
    assign load_nonzero = accept && (i != '0);
    assign d            = top_idx;
    assign i_ready      = !d_valid || (d_last && d_ready);

`ifdef PENC_ZERO_EMIT_EN
    logic zero_q, zero_d;

    // A zero flag is only ever set while pending is empty, so it is its own final beat.
    assign d_valid = (state_q == SCAN) || zero_q;
    assign d_last  = single_bit || zero_q;
    assign none    = zero_q;

    always_comb begin
        zero_d = zero_q;
        if (d_hs && zero_q) zero_d = 1'b0;
        if (accept)         zero_d = (i == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) zero_q <= 1'b0;
        else        zero_q <= zero_d;
    end
`else
    assign d_valid = (state_q == SCAN);
    assign d_last  = single_bit;
    assign none    = 1'b0;
`endif

    // Load after clear: a same-cycle acceptance replaces the final-bit clear.
    always_comb begin
        pending_d = pending_q;
        if (d_hs)   pending_d = pending_q & ~top_onehot;
        if (accept) pending_d = i;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_nonzero) state_d = SCAN;
            SCAN:    if (d_hs && d_last && !load_nonzero) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

endmodule
